// File: rtl/mux_n_reg.sv
// N-channel registered multiplexer with valid/ready handshakes.
// Explicit-select or round-robin grant feeding one output register.
module mux_n_reg #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    localparam int SEL_W = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   s,
    output logic [WIDTH-1:0]   out,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load_en;
    logic             exp_any;
    logic [SEL_W-1:0] exp_idx;
    logic             rr_any;
    logic [SEL_W-1:0] rr_idx;
    logic             gnt_any;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    int               rr_best;
    int               rr_dist;

    // Output stage can take new data when empty or being drained.
    always_comb begin
        load_en = !valid_q || out_ready;
    end

    // Explicit grant: selected channel only; indices >= N never match.
    always_comb begin
        exp_any = 1'b0;
        exp_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (s == SEL_W'(i)) begin
                exp_idx = SEL_W'(i);
                exp_any = in_valid[i];
            end
        end
    end

    // Round-robin grant: valid channel nearest to ptr going upward, wrapping.
    always_comb begin
        rr_any  = 1'b0;
        rr_idx  = '0;
        rr_best = N;
        rr_dist = 0;
        for (int i = 0; i < N; i++) begin
            if (i >= int'(ptr_q)) begin
                rr_dist = i - int'(ptr_q);
            end else begin
                rr_dist = i + N - int'(ptr_q);
            end
            if (in_valid[i] && (rr_dist < rr_best)) begin
                rr_best = rr_dist;
                rr_idx  = SEL_W'(i);
                rr_any  = 1'b1;
            end
        end
    end

    // Pick the active grant source according to the current mode.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (mode) begin
            gnt_any = rr_any;
            gnt_idx = rr_idx;
        end else begin
            gnt_any = exp_any;
            gnt_idx = exp_idx;
        end
    end

    // Data mux for the granted channel.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data = in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept strobe back to the granted producer; silent during reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = gnt_any && load_en && !rst &&
                          (gnt_idx == SEL_W'(i));
        end
    end

    // Next-state for the output register and round-robin pointer.
    always_comb begin
        out_d   = out_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            if (gnt_any) begin
                out_d   = gnt_data;
                sel_d   = gnt_idx;
                valid_d = 1'b1;
                if (mode) begin
                    if (int'(gnt_idx) == N - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gnt_idx + SEL_W'(1);
                    end
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            out_q   <= out_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out       = out_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_n_reg.sv
// Bench for mux_n_reg: N=4 table vectors plus N=3 wrap/out-of-range sequence.
// Inputs change 1 time unit after a rising edge; outputs read 1 unit after.
module tb_mux_n_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic        rst;
    logic [63:0] in;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  s;
    logic [15:0] out;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    mux_n_reg #(.WIDTH(16), .N(4)) u4 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .s(s), .out(out),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    // N=3 instance
    logic        rst3;
    logic [47:0] in3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  s3;
    logic [15:0] out3;
    logic [1:0]  out_sel3;
    logic        out_valid3;
    logic        out_ready3;

    mux_n_reg #(.WIDTH(16), .N(3)) u3 (
        .clk(clk), .rst(rst3), .in(in3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .s(s3), .out(out3),
        .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        mode;
        logic [1:0]  s;
        logic [3:0]  vld;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [1:0]  e_sel;
        logic [15:0] e_out;
    } vec_t;

    localparam int NV = 20;
    vec_t tv [NV];

    localparam logic [63:0] STD_IN = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_check(input vec_t v, input string tag);
        rst       = v.rst;
        mode      = v.mode;
        s         = v.s;
        in_valid  = v.vld;
        out_ready = v.ordy;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(v.e_rdy));
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v.e_ov));
        check({tag, ".out_sel"}, 32'(out_sel), 32'(v.e_sel));
        check({tag, ".out"}, 32'(out), 32'(v.e_out));
    endtask

    task automatic drive3(input logic r, input logic m, input logic [1:0] sv,
                          input logic [2:0] vld, input logic [2:0] e_rdy,
                          input logic e_ov, input logic [1:0] e_sel,
                          input logic [15:0] e_out, input string tag);
        rst3       = r;
        mode3      = m;
        s3         = sv;
        in_valid3  = vld;
        out_ready3 = 1'b1;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready3), 32'(e_rdy));
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 32'(out_valid3), 32'(e_ov));
        check({tag, ".out_sel"}, 32'(out_sel3), 32'(e_sel));
        check({tag, ".out"}, 32'(out3), 32'(e_out));
    endtask

    initial begin
        // rst mode s vld ordy | rdy ov sel out
        tv[0]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};
        tv[1]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};
        tv[2]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'hAAAA};
        tv[3]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hBBBB};
        tv[4]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hCCCC};
        tv[5]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'hDDDD};
        tv[6]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'hAAAA};
        tv[7]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hBBBB};
        tv[8]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hCCCC};
        tv[9]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'hDDDD};
        tv[10] = '{1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hBBBB};
        tv[11] = '{1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 16'hDDDD};
        tv[12] = '{1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hBBBB};
        tv[13] = '{1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 16'hDDDD};
        tv[14] = '{1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hCCCC};
        tv[15] = '{1'b0, 1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 2'd2, 16'hCCCC};
        tv[16] = '{1'b0, 1'b0, 2'd1, 4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 16'hBBBB};
        tv[17] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 16'hBBBB};
        tv[18] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'hAAAA};
        tv[19] = '{1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'hAAAA};

        in         = STD_IN;
        rst3       = 1'b1;
        in3        = {16'h3333, 16'h2222, 16'h1111};
        in_valid3  = 3'b111;
        mode3      = 1'b0;
        s3         = 2'd0;
        out_ready3 = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive_check(tv[i], $sformatf("vec%0d", i));
        end

        // back-pressure: load ch2, stall three cycles with inputs moving
        drive_check('{1'b0, 1'b0, 2'd2, 4'b1111, 1'b1,
                      4'b0100, 1'b1, 2'd2, 16'hCCCC}, "bp_load");
        in = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        drive_check('{1'b0, 1'b0, 2'd0, 4'b1111, 1'b0,
                      4'b0000, 1'b1, 2'd2, 16'hCCCC}, "bp_stall0");
        in = {16'h5A5A, 16'hA5A5, 16'h0F0F, 16'hF0F0};
        drive_check('{1'b0, 1'b1, 2'd3, 4'b0110, 1'b0,
                      4'b0000, 1'b1, 2'd2, 16'hCCCC}, "bp_stall1");
        in = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
        drive_check('{1'b0, 1'b0, 2'd1, 4'b1111, 1'b0,
                      4'b0000, 1'b1, 2'd2, 16'hCCCC}, "bp_stall2");
        in = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'h1234};
        drive_check('{1'b0, 1'b0, 2'd0, 4'b1111, 1'b1,
                      4'b0001, 1'b1, 2'd0, 16'h1234}, "bp_release");
        in = STD_IN;

        // reset mid-stream under round-robin (ptr is 1 here)
        drive_check('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1,
                      4'b0010, 1'b1, 2'd1, 16'hBBBB}, "mid_load");
        drive_check('{1'b1, 1'b1, 2'd0, 4'b1111, 1'b0,
                      4'b0000, 1'b0, 2'd0, 16'h0000}, "mid_rst");
        drive_check('{1'b0, 1'b1, 2'd0, 4'b1110, 1'b1,
                      4'b0010, 1'b1, 2'd1, 16'hBBBB}, "mid_after");

        // N=3: out-of-range select and pointer wrap
        drive3(1'b1, 1'b0, 2'd0, 3'b111, 3'b000, 1'b0, 2'd0, 16'h0000, "n3_rst");
        drive3(1'b0, 1'b0, 2'd3, 3'b111, 3'b000, 1'b0, 2'd0, 16'h0000, "n3_s3");
        drive3(1'b0, 1'b1, 2'd0, 3'b111, 3'b001, 1'b1, 2'd0, 16'h1111, "n3_rr0");
        drive3(1'b0, 1'b1, 2'd0, 3'b111, 3'b010, 1'b1, 2'd1, 16'h2222, "n3_rr1");
        drive3(1'b0, 1'b1, 2'd0, 3'b111, 3'b100, 1'b1, 2'd2, 16'h3333, "n3_rr2");
        drive3(1'b0, 1'b1, 2'd0, 3'b111, 3'b001, 1'b1, 2'd0, 16'h1111, "n3_wrap");
        drive3(1'b0, 1'b0, 2'd2, 3'b111, 3'b100, 1'b1, 2'd2, 16'h3333, "n3_s2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
